// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result and NZCV flags
// Define ALU_ITER_SHIFT_EN to shift LSL/LSR one bit per cycle instead of using a barrel shifter.
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [3:0]         flags
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NEG = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_ORR = 3'd4;
  localparam logic [2:0] OP_EOR = 3'd5;
  localparam logic [2:0] OP_LSL = 3'd6;
  localparam logic [2:0] OP_LSR = 3'd7;

  logic             accept;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH:0]   wide;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    wide  = '0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = a - b;
        res_c = (a >= b);
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NEG: res = ~b;
      OP_AND: res = a & b;
      OP_ORR: res = a | b;
      OP_EOR: res = a ^ b;
`ifdef ALU_ITER_SHIFT_EN
      // Only shamt==0 shifts complete here; the rest run through SHIFT.
      OP_LSL, OP_LSR: res = a;
`else
      // The extra bit of the widened operand catches the last bit shifted out.
      OP_LSL: begin
        wide  = {1'b0, a} << shamt;
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
      end
      OP_LSR: begin
        wide  = {a, 1'b0} >> shamt;
        res   = wide[WIDTH:1];
        res_c = wide[0];
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_ITER_SHIFT_EN
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   sh_q;
  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_right;
  logic               sh_bit;
  logic               start_shift;
  logic               last_step;

  assign start_shift = accept && ((op == OP_LSL) || (op == OP_LSR)) && (shamt != '0);
  assign last_step   = (state == SHIFT) && (cnt == SHAMT_W'(1));
  assign sh_nxt      = sh_right ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
  assign sh_bit      = sh_right ? sh_q[0] : sh_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_shift) state_nxt = SHIFT;
      SHIFT:   if (cnt == SHAMT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end
`else
  always_comb begin
    in_ready = !out_valid || out_ready;
  end
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
`ifdef ALU_ITER_SHIFT_EN
      cnt       <= '0;
      sh_q      <= '0;
      sh_right  <= 1'b0;
`endif
    end else begin
`ifdef ALU_ITER_SHIFT_EN
      if (start_shift) begin
        // Accept implies any pending result is dropped on this edge.
        cnt       <= shamt;
        sh_q      <= a;
        sh_right  <= (op == OP_LSR);
        out_valid <= 1'b0;
      end else if (state == SHIFT) begin
        cnt  <= cnt - SHAMT_W'(1);
        sh_q <= sh_nxt;
        if (last_step) begin
          out       <= sh_nxt;
          flags     <= {sh_nxt[WIDTH-1], (sh_nxt == '0), sh_bit, 1'b0};
          out_valid <= 1'b1;
        end
      end else
`endif
      if (accept) begin
        out       <= res;
        flags     <= {res[WIDTH-1], (res == '0), res_c, res_v};
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe at WIDTH 8 and 16
// Build with ALU_ITER_SHIFT_EN to check the iterative-shift latencies.
module tb_alu_pipe;

`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, o8;
  logic [2:0]  op8 = '0, sh8 = '0;
  logic [3:0]  f8;

  logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, o16;
  logic [2:0]  op16 = '0;
  logic [3:0]  sh16 = '0;
  logic [3:0]  f16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .op(op8), .shamt(sh8), .out_valid(ov8), .out_ready(ordy8), .out(o8), .flags(f8)
  );

  alu_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .op(op16), .shamt(sh16), .out_valid(ov16), .out_ready(ordy16), .out(o16), .flags(f16)
  );

  // Returns {N,Z,C,V, result[15:0]} from plain integer arithmetic.
  function automatic logic [19:0] model(input int w, input int opc, input longint x,
                                        input longint y, input int s);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint sx   = (x >= half) ? x - 2 * half : x;
    longint sy   = (y >= half) ? y - 2 * half : y;
    longint r    = 0;
    longint sr   = 0;
    bit     c    = 1'b0;
    bit     v    = 1'b0;
    bit     n;
    bit     z;
    case (opc)
      0: begin r = x + y; c = (r > m); sr = sx + sy; v = (sr >= half) || (sr < -half); end
      1: begin r = x - y; c = (x >= y); sr = sx - sy; v = (sr >= half) || (sr < -half); end
      2: r = ~y;
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: begin r = x << s; c = (s != 0) && (((x >> (w - s)) & 1) != 0); end
      default: begin r = x >> s; c = (s != 0) && (((x >> (s - 1)) & 1) != 0); end
    endcase
    r = r & m;
    n = ((r >> (w - 1)) & 1) != 0;
    z = (r == 0);
    return {n, z, c, v, 16'(r)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input string tag, input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [2:0] s);
    logic [19:0] e;
    int lat;
    int stall;
    int elat;
    e = model(8, int'(o), longint'(x), longint'(y), int'(s));
    elat = (ITER && o >= 3'd6 && s != 3'd0) ? 1 + int'(s) : 1;
    op8 = o; a8 = x; b8 = y; sh8 = s; iv8 = 1'b1; ordy8 = 1'b1;
    #1;
    chk({tag, ":in_ready"}, 32'(ir8), 32'(1));
    tick();
    iv8 = 1'b0;
    lat = 1;
    stall = 0;
    while (!ov8 && lat < 64) begin
      if (!ir8) stall++;
      tick();
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(elat));
    chk({tag, ":stall"}, 32'(stall), 32'(elat - 1));
    chk({tag, ":out"}, 32'(o8), 32'(e[7:0]));
    chk({tag, ":nzcv"}, 32'(f8), 32'(e[19:16]));
  endtask

  task automatic send16(input string tag, input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [3:0] s);
    logic [19:0] e;
    int lat;
    int elat;
    e = model(16, int'(o), longint'(x), longint'(y), int'(s));
    elat = (ITER && o >= 3'd6 && s != 4'd0) ? 1 + int'(s) : 1;
    op16 = o; a16 = x; b16 = y; sh16 = s; iv16 = 1'b1; ordy16 = 1'b1;
    #1;
    chk({tag, ":in_ready"}, 32'(ir16), 32'(1));
    tick();
    iv16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 64) begin
      tick();
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(elat));
    chk({tag, ":out"}, 32'(o16), 32'(e[15:0]));
    chk({tag, ":nzcv"}, 32'(f16), 32'(e[19:16]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [19:0] q[$];
    logic [19:0] e;
    int n;

    // Reset state
    tick();
    tick();
    chk("rst:ov8", 32'(ov8), 32'(0));
    chk("rst:out8", 32'(o8), 32'(0));
    chk("rst:f8", 32'(f8), 32'(0));
    chk("rst:ov16", 32'(ov16), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("rst:ir8", 32'(ir8), 32'(1));
    chk("rst:ir16", 32'(ir16), 32'(0) | 32'(1));

    // Directed cases from the worked examples
    send8("add_ff_01", 3'd0, 8'hFF, 8'h01, 3'd0);
    chk("add_ff_01:val", 32'({f8, o8}), 32'(12'h600));
    send8("sub_80_01", 3'd1, 8'h80, 8'h01, 3'd0);
    chk("sub_80_01:val", 32'({f8, o8}), 32'(12'h37F));
    send8("sub_01_02", 3'd1, 8'h01, 8'h02, 3'd0);
    chk("sub_01_02:val", 32'({f8, o8}), 32'(12'h8FF));
    send8("lsl_81_1", 3'd6, 8'h81, 8'h00, 3'd1);
    chk("lsl_81_1:val", 32'({f8, o8}), 32'(12'h202));
    send8("lsr_80_7", 3'd7, 8'h80, 8'h00, 3'd7);
    chk("lsr_80_7:out", 32'(o8), 32'(8'h01));
    send8("lsl_sh0", 3'd6, 8'hC3, 8'h00, 3'd0);
    send8("neg", 3'd2, 8'h12, 8'h0F, 3'd0);

    // Backpressure: AND result held, EOR waits, then accepted when out_ready rises
    tick();
    ordy8 = 1'b0;
    op8 = 3'd3; a8 = 8'h5A; b8 = 8'h0F; sh8 = 3'd0; iv8 = 1'b1;
    #1;
    chk("bp:first_ready", 32'(ir8), 32'(1));
    tick();
    op8 = 3'd5;
    for (int i = 0; i < 3; i++) begin
      chk("bp:hold_valid", 32'(ov8), 32'(1));
      chk("bp:hold_out", 32'(o8), 32'(8'h0A));
      chk("bp:hold_ready", 32'(ir8), 32'(0));
      tick();
    end
    ordy8 = 1'b1;
    #1;
    chk("bp:ready_same_cycle", 32'(ir8), 32'(1));
    tick();
    iv8 = 1'b0;
    chk("bp:second_valid", 32'(ov8), 32'(1));
    chk("bp:second_out", 32'(o8), 32'(8'h55));

    // Reset in the middle of a long right shift
    op8 = 3'd7; a8 = 8'h80; sh8 = 3'd7; iv8 = 1'b1;
    #1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst:ov", 32'(ov8), 32'(0));
    chk("midrst:out", 32'(o8), 32'(0));
    chk("midrst:flags", 32'(f8), 32'(0));
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst:ir_after", 32'(ir8), 32'(1));
    for (int i = 0; i < 8; i++) tick();
    chk("midrst:no_partial", 32'(ov8), 32'(0));

    // 16-bit datapath
    send16("add16_7fff_1", 3'd0, 16'h7FFF, 16'h0001, 4'd0);
    chk("add16_7fff_1:val", 32'({f16, o16}), 32'(20'h98000));
    send16("lsl16_15", 3'd6, 16'h0003, 16'h0000, 4'd15);

    // Random single beats
    for (int i = 0; i < 40; i++)
      send8("rnd8", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 3'($urandom));
    for (int i = 0; i < 20; i++)
      send16("rnd16", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom));

    // Random streaming with random backpressure, scoreboarded in order
    tick();
    for (int cyc = 0; cyc < 300; cyc++) begin
      iv8 = ($urandom_range(0, 3) != 0);
      ordy8 = ($urandom_range(0, 3) != 0);
      op8 = 3'($urandom_range(0, 7));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      sh8 = 3'($urandom);
      #1;
      if (ov8 && !ordy8) chk("stream:stall_ready", 32'(ir8), 32'(0));
      if (ov8 && ordy8) begin
        chk("stream:expected_beat", 32'(q.size() != 0), 32'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("stream:out", 32'(o8), 32'(e[7:0]));
          chk("stream:nzcv", 32'(f8), 32'(e[19:16]));
        end
      end
      if (iv8 && ir8) q.push_back(model(8, int'(op8), longint'(a8), longint'(b8), int'(sh8)));
      tick();
    end
    iv8 = 1'b0;
    ordy8 = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      #1;
      if (ov8) begin
        e = q.pop_front();
        chk("drain:out", 32'(o8), 32'(e[7:0]));
        chk("drain:nzcv", 32'(f8), 32'(e[19:16]));
      end
      tick();
      n++;
    end
    chk("drain:empty", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 8-bit datapath ALU. It executes the same eight `ALU_OP_*` operations from `alu.vh` at any power-of-two width and registers a result plus a real NZCV flag vector. Operands arrive on a valid/ready input channel and results leave on a valid/ready output channel, so the block sits between the decode stage and writeback and can absorb writeback stalls.

## Interface
- `WIDTH`, default 8: datapath width; power of two, at least 4.
- `SHAMT_W`, default `$clog2(WIDTH)`: shift-amount width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand/op beat is valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `a`, `b`  in  WIDTH  operands.
- `op`  in  3  `ALU_OP_ADD/SUB/NEG/AND/ORR/EOR/LSL/LSR` encoding from `alu.vh`.
- `shamt`  in  SHAMT_W  shift amount; used by LSL/LSR only.
- `out_valid`  out  1  result beat is valid.
- `out_ready`  in  1  downstream accepts the result.
- `out`  out  WIDTH  registered result.
- `flags`  out  4  registered `{N,Z,C,V}`.

## Operation
- Accept: `in_valid && in_ready`. Drop: `out_valid && out_ready`.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`. Accept and drop may occur in the same cycle.
- Results are computed modulo 2^WIDTH:
  - ADD: a+b.
  - SUB: a-b.
  - NEG: ~b (bitwise).
  - AND, ORR, EOR: a&b, a|b, a^b.
  - LSL: a<<shamt.
  - LSR: a>>shamt (logical).
- Flags:
  - N = out[WIDTH-1].
  - Z = (out==0).
  - C for ADD: carry out of bit WIDTH-1.
  - C for SUB: 1 when a>=b unsigned (no borrow).
  - C for LSL: last bit shifted out, a[WIDTH-shamt].
  - C for LSR: a[shamt-1].
  - C for a shift with shamt=0: 0. C for NEG and logic ops: 0.
  - V for ADD: a and b have the same sign and out's sign differs.
  - V for SUB: a and b have different signs and out's sign differs from a.
  - V for all other ops: 0.
- States: IDLE and SHIFT. SHIFT exists only with `ALU_ITER_SHIFT_EN`.
  - IDLE→SHIFT on accepting LSL/LSR with shamt≠0 (iterative build only).
  - SHIFT→IDLE when the remaining count reaches 0; `out_valid` rises on that transition.
- While `out_valid && !out_ready`, `out` and `flags` hold stable and no new beat is accepted.
- Reset values: `out`=0, `flags`=0, `out_valid`=0, state IDLE, count 0. `in_ready` reads 1 once `rst_n` is high.
- Reset mid-operation (any state) aborts the operation; no partial result is ever presented.

## Timing
- Non-shift ops and barrel shifts: `out_valid` rises on the clock edge that accepts the beat (latency 1). Throughput is 1 beat/cycle while `out_ready`=1.
- Iterative shifts: latency 1+shamt cycles; `in_ready`=0 for the shamt cycles spent in SHIFT. A shift with shamt=0 takes the 1-cycle path.
- `out_valid` falls on the drop edge unless a new beat is accepted on the same edge.
- No combinational path from `in_valid`, `a`, `b` or `op` to any output. The only combinational paths are `out_ready`→`in_ready` and state→`in_ready`.

## Configuration
- `ALU_ITER_SHIFT_EN` defined: LSL/LSR shift one bit per cycle through a SHAMT_W-bit down-counter and a WIDTH-bit shift register. This saves area; C is captured on the final step.
- `ALU_ITER_SHIFT_EN` undefined: single-cycle barrel shifter, the SHIFT state and counter are removed, and every op has latency 1.

## Test plan
- WIDTH=8, ADD a=0xFF, b=0x01 → `out`=0x00, NZCV=0110, `out_valid` one cycle after accept.
- SUB a=0x80, b=0x01 → `out`=0x7F, NZCV=0011. SUB a=0x01, b=0x02 → `out`=0xFF, NZCV=1000.
- LSL a=0x81, shamt=1 → `out`=0x02, C=1.
  - With `ALU_ITER_SHIFT_EN`: LSR a=0x80, shamt=7 → `out`=0x01, `out_valid` 8 cycles after accept, `in_ready`=0 for 7 cycles.
- Back-to-back AND then EOR with `out_ready` held low 3 cycles → first result stable, `in_ready`=0. When `out_ready` rises, the second beat is accepted that same cycle.
- Assert `rst_n`=0 mid-way through LSR shamt=7 → `out_valid`=0, `out`=0, `flags`=0 immediately; `in_ready`=1 after release.
- WIDTH=16, ADD a=0x7FFF, b=0x0001 → `out`=0x8000, NZCV=1001.
